// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared constants for the RV32 multi-cycle sequencer and
//                its decoder: FSM state codes, NOP word and base opcodes.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

   // Sequencer FSM state width and codes. Codes 5..7 are illegal.
   localparam int STATE_W = 3;

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;

   // addi x0, x0, 0 -- loaded into the instruction register on reset so the
   // decoder never sees garbage before the first fetch completes.
   localparam logic [31:0] NOP_INST = 32'h00000013;

   // RV32I base opcodes shared with the decoder.
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // Opcode field of an instruction word.
   function automatic logic [6:0] opcode_of(input logic [31:0] word);
      return word[6:0];
   endfunction

   // True for the five defined state codes.
   function automatic logic is_legal_state(input logic [STATE_W-1:0] s);
      return (s <= WB);
   endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/core_sequencer_pc_next.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next
//  Description : Next-PC select and adder. Either pc + jump_offset (taken
//                branch) or pc + 4; both wrap modulo 2^32.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_next
   import core_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] jump_offset,
   input  logic        take,
   output logic [31:0] next_pc
);

   // Single adder with a muxed second operand; the carry out is dropped,
   // which gives the required wrap-around.
   logic [31:0] addend;

   // Pick the increment: signed offset for a taken branch, else 4.
   always_comb begin
      addend  = take ? jump_offset : 32'd4;
      next_pc = pc + addend;
   end

endmodule : pc_next
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : core_sequencer
//  Description : Multi-cycle RV32 control sequencer. Fetches over an imem
//                handshake, holds the instruction register, walks
//                DECODE/EXEC/MEM/WB, issues one dmem transaction and one
//                register-file write strobe per instruction, and owns the
//                PC and retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module core_sequencer
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic               clk,
   input  logic               rst_n,
   // instruction memory
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   // decoder interface
   output logic [31:0]        inst,
   input  logic               dec_w_en,
   input  logic               dec_mw_en,
   input  logic               dec_maddr_sel,
   input  logic               dec_jump_en,
   input  logic               br_taken,
   input  logic [31:0]        jump_offset,
   // data memory
   output logic               dmem_req,
   output logic               dmem_we,
   input  logic               dmem_ack,
   // register file
   output logic               rf_we,
   // status
   output logic [31:0]        pc,
   output logic [31:0]        retired,
   output logic [STATE_W-1:0] state
);

   logic [STATE_W-1:0] cur_state;
   logic [STATE_W-1:0] nxt_state;
   logic               store_q;     // store flag captured for the MEM phase
   logic               wr_en_q;     // write enable captured for the WB phase
   logic               take_branch;
   logic [31:0]        pc_plus;

   // --------------------------------------------------------------------
   // Next-PC datapath
   // --------------------------------------------------------------------
   assign take_branch = dec_jump_en & br_taken;

   pc_next u_pc_next (
      .pc          (pc),
      .jump_offset (jump_offset),
      .take        (take_branch),
      .next_pc     (pc_plus)
   );

   // Next-state logic; illegal codes fall back to FETCH.
   always_comb begin
      nxt_state = FETCH;
      case (cur_state)
         FETCH:   nxt_state = imem_ack ? DECODE : FETCH;
         DECODE:  nxt_state = EXEC;
         EXEC:    nxt_state = (dec_mw_en | dec_maddr_sel) ? MEM : WB;
         MEM:     nxt_state = dmem_ack ? WB : MEM;
         WB:      nxt_state = FETCH;
         default: nxt_state = FETCH;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= FETCH;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Capture the store flag on every edge that lands in MEM so dmem_we is a
   // pure function of flops (the decoder flag is stable for the whole
   // instruction, so this is equivalent to using it directly).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_q <= 1'b0;
      end else if (nxt_state == MEM) begin
         store_q <= dec_mw_en;
      end
   end

   // Capture the register-write enable on the edge that enters WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q <= 1'b0;
      end else if (nxt_state == WB) begin
         wr_en_q <= dec_w_en;
      end
   end

   // Instruction register: only an acknowledged fetch may load it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst <= NOP_INST;
      end else if ((cur_state == FETCH) && imem_ack) begin
         inst <= imem_rdata;
      end
   end

   // PC and retired counter advance together at the end of writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         retired <= 32'd0;
      end else if (cur_state == WB) begin
         pc      <= pc_plus;
         retired <= retired + 32'd1;
      end
   end

   // Handshake and strobe outputs decoded from state and captured flags
   // only, so no input reaches them combinationally.
   always_comb begin
      imem_req = (cur_state == FETCH);
      dmem_req = (cur_state == MEM);
      dmem_we  = (cur_state == MEM) & store_q;
      rf_we    = (cur_state == WB) & wr_en_q;
   end

   assign imem_addr = pc;
   assign state     = cur_state;

endmodule : core_sequencer
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_sequencer
//  Description : Scoreboard bench for core_sequencer. A driver plays the
//                memories and decoder per instruction and queues the
//                expected outcome; a monitor pops it at each writeback.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_core_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, rf_we;
   logic [31:0] imem_addr, imem_rdata, inst, jump_offset, pc, retired;
   logic        dec_w_en, dec_mw_en, dec_maddr_sel, dec_jump_en, br_taken;
   logic [2:0]  state;

   // Second instance with a reset PC just below the wrap point.
   logic        w_imem_req, w_dmem_req, w_dmem_we, w_rf_we;
   logic [31:0] w_imem_addr, w_inst, w_pc, w_retired;
   logic [2:0]  w_state;

   always #5 clk = ~clk;

   core_sequencer #(.RESET_PC(32'h00000000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst(inst), .dec_w_en(dec_w_en), .dec_mw_en(dec_mw_en), .dec_maddr_sel(dec_maddr_sel),
      .dec_jump_en(dec_jump_en), .br_taken(br_taken), .jump_offset(jump_offset),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .pc(pc), .retired(retired), .state(state)
   );

   core_sequencer #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(1'b1), .imem_rdata(32'h00000013),
      .inst(w_inst), .dec_w_en(1'b0), .dec_mw_en(1'b0), .dec_maddr_sel(1'b0),
      .dec_jump_en(1'b0), .br_taken(1'b0), .jump_offset(32'd0),
      .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_ack(1'b0),
      .rf_we(w_rf_we), .pc(w_pc), .retired(w_retired), .state(w_state)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
      int          cycles;
      int          dcyc;
      int          wecyc;
      int          rfcnt;
      logic [31:0] npc;
      logic [31:0] nret;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   bit          mon_en = 1'b0;
   logic [31:0] m_pc;
   logic [31:0] m_ret;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Play one instruction: imem with iwait stall cycles, decoder flags held,
   // dmem with dwait stall cycles. Acks to idle request lines are random.
   task automatic run_instr(input logic [31:0] word, input logic w, input logic mw,
                            input logic ms, input logic jmp, input logic tk,
                            input logic [31:0] off, input int iwait, input int dwait);
      exp_t e;
      bit   mem;
      mem     = mw | ms;
      e.addr  = m_pc;
      e.word  = word;
      e.dcyc  = mem ? dwait + 1 : 0;
      e.wecyc = mw ? e.dcyc : 0;
      e.rfcnt = w ? 1 : 0;
      e.cycles = 1 + iwait + 2 + e.dcyc + 1;
      m_pc    = (jmp && tk) ? m_pc + off : m_pc + 32'd4;
      m_ret   = m_ret + 32'd1;
      e.npc   = m_pc;
      e.nret  = m_ret;
      sb.push_back(e);

      dec_w_en = w; dec_mw_en = mw; dec_maddr_sel = ms;
      dec_jump_en = jmp; br_taken = tk; jump_offset = off;
      for (int k = 0; k <= iwait; k++) begin
         imem_ack   = (k == iwait);
         imem_rdata = (k == iwait) ? word : $urandom;
         dmem_ack   = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         imem_ack   = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         dmem_ack   = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      if (mem) begin
         for (int k = 0; k <= dwait; k++) begin
            dmem_ack   = (k == dwait);
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            @(negedge clk);
         end
      end
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      dmem_ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
   endtask

   // Monitor: accumulate what the DUT does over one instruction and compare
   // against the queued expectation when it reaches writeback.
   initial begin
      exp_t        e;
      int          cyc, dcnt, wecnt, rfcnt, rfat;
      logic [31:0] faddr, iword, pnpc, pnret;
      bit          pend;
      cyc = 0; dcnt = 0; wecnt = 0; rfcnt = 0; rfat = 0;
      faddr = '0; iword = '0; pnpc = '0; pnret = '0; pend = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!mon_en) begin
            cyc = 0; dcnt = 0; wecnt = 0; rfcnt = 0; pend = 1'b0;
            continue;
         end
         if (pend) begin
            check("next_pc", pc, pnpc);
            check("next_imem_addr", imem_addr, pnpc);
            check("retired", retired, pnret);
            check("back_to_fetch", {29'd0, state}, 32'd0);
            pend = 1'b0;
         end
         cyc++;
         if (state == 3'd0 && imem_ack) faddr = imem_addr;
         if (state == 3'd1) iword = inst;
         if (dmem_req) begin
            dcnt++;
            if (dmem_we) wecnt++;
            check("req_exclusive", {31'd0, imem_req}, 32'd0);
         end
         if (rf_we) begin
            rfcnt++;
            rfat = cyc;
         end
         if (state == 3'd4) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_wb: got writeback required none");
            end else begin
               e = sb.pop_front();
               check("fetch_addr", faddr, e.addr);
               check("inst_reg", iword, e.word);
               check("cycles", cyc, e.cycles);
               check("dmem_cycles", dcnt, e.dcyc);
               check("dmem_we_cycles", wecnt, e.wecyc);
               check("rf_we_pulses", rfcnt, e.rfcnt);
               if (e.rfcnt != 0) check("rf_we_cycle", rfat, e.cycles);
               pnpc = e.npc; pnret = e.nret; pend = 1'b1;
            end
            cyc = 0; dcnt = 0; wecnt = 0; rfcnt = 0; rfat = 0;
         end else if (cyc > 60) begin
            total++; bad++;
            $display("FAIL wb_timeout: got %0d cycles without writeback required <=60", cyc);
            cyc = 0; dcnt = 0; wecnt = 0; rfcnt = 0;
         end
      end
   end

   // Wrap instance: first fetch on the first edge, pc wraps to 0 after one
   // non-branch instruction.
   initial begin
      @(posedge rst_n);
      @(posedge clk); #1;
      check("wrap_first_fetch_state", {29'd0, w_state}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("wrap_pc", w_pc, 32'd0);
      check("wrap_imem_addr", w_imem_addr, 32'd0);
      check("wrap_retired", w_retired, 32'd1);
   end

   initial begin
      int wait_cnt;
      rst_n = 1'b0;
      imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0;
      dec_w_en = 1'b0; dec_mw_en = 1'b0; dec_maddr_sel = 1'b0;
      dec_jump_en = 1'b0; br_taken = 1'b0; jump_offset = '0;
      m_pc = 32'd0; m_ret = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_inst", inst, 32'h00000013);
      check("rst_retired", retired, 32'd0);
      check("rst_imem_req", {31'd0, imem_req}, 32'd1);
      check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
      check("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check("rst_wrap_pc", w_pc, 32'hFFFFFFFC);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Directed: ALU, load with 3 waits, store, then branch at pc=16.
      run_instr(32'h00208033, 1, 0, 0, 0, 0, 32'd0, 0, 0);          // pc 0
      run_instr(32'h0000A083, 1, 0, 1, 0, 0, 32'd0, 0, 3);          // pc 4 load
      run_instr(32'h0020A023, 0, 1, 0, 0, 0, 32'd0, 1, 0);          // pc 8 store
      run_instr(32'h00000013, 1, 1, 1, 0, 0, 32'd0, 0, 1);          // pc 12 both flags
      run_instr(32'hFE000CE3, 0, 0, 0, 1, 1, 32'hFFFFFFF8, 0, 0);   // pc 16 -> 8
      run_instr(32'h00100093, 1, 0, 0, 0, 0, 32'd0, 0, 0);          // pc 8
      run_instr(32'h00100093, 1, 0, 0, 0, 0, 32'd0, 0, 0);          // pc 12
      run_instr(32'hFE000CE3, 0, 0, 0, 1, 0, 32'hFFFFFFF8, 0, 0);   // pc 16 -> 20
      run_instr(32'h00100093, 0, 0, 0, 1, 1, 32'd0, 0, 0);          // taken, zero offset

      // Random instruction mix.
      for (int n = 0; n < 40; n++) begin
         logic [31:0] off;
         off = (32'($urandom_range(0, 255)) - 32'd128) << 2;
         run_instr($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), off,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      check("final_retired", retired, m_ret);
      mon_en = 1'b0;

      // Asynchronous reset mid-cycle while stalled in FETCH with live state.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_pc", pc, 32'd0);
      check("async_rst_retired", retired, 32'd0);
      check("async_rst_state", {29'd0, state}, 32'd0);

      // Reset mid-fetch with ack withheld: nothing retires.
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midfetch_state", {29'd0, state}, 32'd0);
      check("midfetch_pc", pc, 32'd0);
      check("midfetch_retired", retired, 32'd0);
      check("midfetch_imem_req", {31'd0, imem_req}, 32'd1);

      // Reset while a load is stalled in MEM: dmem_req drops at once.
      @(negedge clk);
      rst_n = 1'b1;
      dec_w_en = 1'b1; dec_mw_en = 1'b0; dec_maddr_sel = 1'b1; dec_jump_en = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'h0000A083;
      @(negedge clk);
      imem_ack = 1'b0;
      wait_cnt = 0;
      while (state != 3'd3 && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      #1;
      check("mem_reached", {29'd0, state}, 32'd3);
      check("mem_dmem_req", {31'd0, dmem_req}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midmem_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("midmem_state", {29'd0, state}, 32'd0);
      check("midmem_inst", inst, 32'h00000013);
      check("midmem_retired", retired, 32'd0);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_core_sequencer
`default_nettype wire
